dmem_arbiter: RTL and testbench

Shares the single 32x32 data memory between two requesters:
- Port 0: pipeline MEM stage.
- Port 1: loader/debug port, which preloads and inspects data memory while the core runs.

The block sits between the MEM stage and the data memory macro. It owns all memory enables and addresses, returns read data registered with 1-cycle latency, and raises a stall to the pipeline when port 0 loses arbitration. Port 0 has fixed priority, with a starvation guard for port 1.

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 86 ++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side data memory access port
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester side (MEM stage or loader)
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter, port 0 priority with port 1 starvation guard
module dmem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              stall_mem,
  output logic              mem_wrEnable,
  output logic [ADDR_W-1:0] mem_wrAddress,
  output logic [DATA_W-1:0] mem_wrData,
  output logic              mem_rdEnable,
  output logic [ADDR_W-1:0] mem_rdAddress,
  input  logic [DATA_W-1:0] mem_rdData
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starveCnt;
  logic       force1;
  logic       p0Gnt;
  logic       p1Gnt;

  // Grants are suppressed during reset so nothing issued in that cycle reaches memory
  always_comb begin
    force1 = p1.req && (starveCnt == StarveMax);
    p1Gnt  = !rst && p1.req && (!p0.req || force1);
    p0Gnt  = !rst && p0.req && !p1Gnt;
  end

  assign p0.gnt    = p0Gnt;
  assign p1.gnt    = p1Gnt;
  assign stall_mem = !rst && p0.req && !p0Gnt;

  // Steer the granted port onto the memory; idle bus is driven to zero
  always_comb begin
    mem_wrEnable  = 1'b0;
    mem_rdEnable  = 1'b0;
    mem_wrAddress = '0;
    mem_rdAddress = '0;
    mem_wrData    = '0;
    if (p0Gnt) begin
      mem_wrEnable  = p0.we;
      mem_rdEnable  = !p0.we;
      mem_wrAddress = p0.addr;
      mem_rdAddress = p0.addr;
      if (p0.we) mem_wrData = p0.wdata;
    end else if (p1Gnt) begin
      mem_wrEnable  = p1.we;
      mem_rdEnable  = !p1.we;
      mem_wrAddress = p1.addr;
      mem_rdAddress = p1.addr;
      if (p1.we) mem_wrData = p1.wdata;
    end
  end

  // Capture read data at the end of a granted read; rdata holds until that port reads again
  always_ff @(posedge clk) begin
    if (rst) begin
      p0.rvalid <= 1'b0;
      p1.rvalid <= 1'b0;
      p0.rdata  <= '0;
      p1.rdata  <= '0;
    end else begin
      p0.rvalid <= p0Gnt && !p0.we;
      p1.rvalid <= p1Gnt && !p1.we;
      if (p0Gnt && !p0.we) p0.rdata <= mem_rdData;
      if (p1Gnt && !p1.we) p1.rdata <= mem_rdData;
    end
  end

  // Count consecutive denied port 1 cycles, saturating where the forced grant kicks in
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (p1.req && !p1Gnt) begin
      if (starveCnt != StarveMax) starveCnt <= starveCnt + 4'd1;
    end else begin
      starveCnt <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        stall_mem;
  logic        mem_wrEnable;
  logic [4:0]  mem_wrAddress;
  logic [31:0] mem_wrData;
  logic        mem_rdEnable;
  logic [4:0]  mem_rdAddress;
  logic [31:0] mem_rdData;

  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) p0If ();
  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) p1If ();

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0            (p0If),
    .p1            (p1If),
    .stall_mem     (stall_mem),
    .mem_wrEnable  (mem_wrEnable),
    .mem_wrAddress (mem_wrAddress),
    .mem_wrData    (mem_wrData),
    .mem_rdEnable  (mem_rdEnable),
    .mem_rdAddress (mem_rdAddress),
    .mem_rdData    (mem_rdData)
  );

  logic [31:0] mem [32] = '{default: 32'h0};
  always @(posedge clk) if (mem_wrEnable) mem[mem_wrAddress] <= mem_wrData;
  assign mem_rdData = mem[mem_rdAddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        g0, g1, st;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          row;
    logic        g0, g1, st, we, re;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        rv0, rv1;
    logic        chkZero;
  } exp_t;

  vec_t        vecs[$];
  exp_t        ctlQ[$];
  logic [31:0] rdQ0[$];
  logic [31:0] rdQ1[$];
  int          total = 0;
  int          bad   = 0;
  bit          driveDone = 0;

  function automatic vec_t mk(logic r, logic r0, logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic st, logic [31:0] rd);
    vec_t v;
    v.rst = r; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.st = st; v.rd = rd;
    return v;
  endfunction

  task automatic check(string name, int row, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
    end
  endtask

  // Directed vectors, expected grants/stall/read data worked out by hand (STARVE_MAX = 4)
  initial begin
    logic [31:0] wv [5];
    wv[0] = 32'hA0000000; wv[1] = 32'hA1111111; wv[2] = 32'hA2222222;
    wv[3] = 32'hA3333333; wv[4] = 32'hA4444444;
    // reset with both writers active: nothing may reach memory
    repeat (2) vecs.push_back(mk(1, 1,1,5'd3,32'hAAAAAAAA, 1,1,5'd4,32'hBBBBBBBB, 0,0,0, 0));
    // p1 write then p0 read-back
    vecs.push_back(mk(0, 0,0,5'd0,0, 1,1,5'd5,32'h01010101, 0,1,0, 0));
    vecs.push_back(mk(0, 1,0,5'd5,0, 0,0,5'd0,0, 1,0,0, 32'h01010101));
    // contention: 4 grants to p0, forced p1 on the 5th, twice
    repeat (2) begin
      repeat (4) vecs.push_back(mk(0, 1,0,5'd5,0, 1,0,5'd3,0, 1,0,0, 32'h01010101));
      vecs.push_back(mk(0, 1,0,5'd5,0, 1,0,5'd3,0, 0,1,1, 32'h0));
    end
    vecs.push_back(mk(0, 0,0,5'd0,0, 0,0,5'd0,0, 0,0,0, 0));
    // same-address p0 write vs p1 read
    vecs.push_back(mk(0, 1,1,5'd31,32'h0000ABCD, 1,0,5'd31,0, 1,0,0, 0));
    vecs.push_back(mk(0, 0,0,5'd0,0, 1,0,5'd31,0, 0,1,0, 32'h0000ABCD));
    // build starvation to 3, reset, then counter must restart from 0
    repeat (3) vecs.push_back(mk(0, 1,0,5'd5,0, 1,0,5'd31,0, 1,0,0, 32'h01010101));
    vecs.push_back(mk(1, 1,0,5'd5,0, 1,0,5'd31,0, 0,0,0, 0));
    repeat (4) vecs.push_back(mk(0, 1,0,5'd5,0, 1,0,5'd31,0, 1,0,0, 32'h01010101));
    vecs.push_back(mk(0, 1,0,5'd5,0, 1,0,5'd31,0, 0,1,1, 32'h0000ABCD));
    vecs.push_back(mk(0, 0,0,5'd0,0, 0,0,5'd0,0, 0,0,0, 0));
    // p1 alone: alternating write/read of addrs 0..4
    for (int j = 0; j < 5; j++) begin
      vecs.push_back(mk(0, 0,0,5'd0,0, 1,1,5'(j),wv[j], 0,1,0, 0));
      vecs.push_back(mk(0, 0,0,5'd0,0, 1,0,5'(j),0, 0,1,0, wv[j]));
    end
    repeat (2) vecs.push_back(mk(0, 0,0,5'd0,0, 0,0,5'd0,0, 0,0,0, 0));
  end

  // Driver: apply one vector per cycle and queue what the DUT must show
  initial begin
    vec_t v;
    exp_t e;
    logic prevRd0, prevRd1;
    rst = 1'b1;
    p0If.req = 0; p0If.we = 0; p0If.addr = 0; p0If.wdata = 0;
    p1If.req = 0; p1If.we = 0; p1If.addr = 0; p1If.wdata = 0;
    prevRd0 = 0; prevRd1 = 0;
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst;
      p0If.req = v.r0; p0If.we = v.w0; p0If.addr = v.a0; p0If.wdata = v.d0;
      p1If.req = v.r1; p1If.we = v.w1; p1If.addr = v.a1; p1If.wdata = v.d1;
      e.row   = i;
      e.g0    = v.g0; e.g1 = v.g1; e.st = v.st;
      e.we    = (v.g0 && v.w0) || (v.g1 && v.w1);
      e.re    = (v.g0 && !v.w0) || (v.g1 && !v.w1);
      e.addr  = v.g0 ? v.a0 : (v.g1 ? v.a1 : 5'd0);
      e.wdata = e.we ? (v.g0 ? v.d0 : v.d1) : 32'h0;
      e.rv0   = prevRd0;
      e.rv1   = prevRd1;
      e.chkZero = (i == 2);
      ctlQ.push_back(e);
      if (v.g0 && !v.w0) rdQ0.push_back(v.rd);
      if (v.g1 && !v.w1) rdQ1.push_back(v.rd);
      prevRd0 = v.g0 && !v.w0;
      prevRd1 = v.g1 && !v.w1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    driveDone = 1;
  end

  // Monitor: mid-cycle, pop the expectation for this cycle and compare
  initial begin
    exp_t e;
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (ctlQ.size() > 0) begin
        e = ctlQ.pop_front();
        check("p0_gnt", e.row, 32'(p0If.gnt), 32'(e.g0));
        check("p1_gnt", e.row, 32'(p1If.gnt), 32'(e.g1));
        check("stall_mem", e.row, 32'(stall_mem), 32'(e.st));
        check("mem_wrEnable", e.row, 32'(mem_wrEnable), 32'(e.we));
        check("mem_rdEnable", e.row, 32'(mem_rdEnable), 32'(e.re));
        check("mem_wrAddress", e.row, 32'(mem_wrAddress), 32'(e.addr));
        check("mem_rdAddress", e.row, 32'(mem_rdAddress), 32'(e.addr));
        if (e.we) check("mem_wrData", e.row, mem_wrData, e.wdata);
        check("p0_rvalid", e.row, 32'(p0If.rvalid), 32'(e.rv0));
        check("p1_rvalid", e.row, 32'(p1If.rvalid), 32'(e.rv1));
        if (e.chkZero) begin
          check("p0_rdata_reset", e.row, p0If.rdata, 32'h0);
          check("p1_rdata_reset", e.row, p1If.rdata, 32'h0);
        end
        if (p0If.rvalid === 1'b1 && e.rv0 && rdQ0.size() > 0) begin
          want = rdQ0.pop_front();
          check("p0_rdata", e.row, p0If.rdata, want);
        end
        if (p1If.rvalid === 1'b1 && e.rv1 && rdQ1.size() > 0) begin
          want = rdQ1.pop_front();
          check("p1_rdata", e.row, p1If.rdata, want);
        end
      end
    end
  end

  // Finish once the driver is done and the monitor has drained
  initial begin
    wait (driveDone);
    @(negedge clk);
    check("p0_rdata_pending", -1, 32'(rdQ0.size()), 32'd0);
    check("p1_rdata_pending", -1, 32'(rdQ1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
